// File: rtl/game_seq_pkg.sv
// rtl/game_seq_pkg.sv - state encoding and sizing helpers for the game sequencer
package game_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT  = 3'd0,
      ST_ARMED = 3'd1,
      ST_PAINT = 3'd2,
      ST_RUN   = 3'd3,
      ST_CLEAR = 3'd4,
      ST_PAUSE = 3'd5
   } state_t;

   function automatic int maxOf4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/game_seq_timer.sv
// rtl/game_seq_timer.sv - loadable phase up-counter with clear, hold and terminal-count compare
module game_seq_timer #(
   parameter int W = 4
) (
   input  logic         iClk,
   input  logic         iReset_n,
   input  logic         iClear,
   input  logic         iHold,
   input  logic         iLoad,
   input  logic [W-1:0] iLoadVal,
   input  logic [W-1:0] iTermVal,
   output logic [W-1:0] oCount,
   output logic         oTerm
);

   // Clear wins over load, load over hold, hold over count.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         oCount <= '0;
      end else if (iClear) begin
         oCount <= '0;
      end else if (iLoad) begin
         oCount <= iLoadVal;
      end else if (!iHold) begin
         oCount <= oCount + W'(1);
      end
   end

   assign oTerm = (oCount == iTermVal);

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - parametrised game master FSM: init, arm, paint, run, clear, round count
// Optional pause state and iPause port are built only with GAME_SEQ_PAUSE_EN defined.
module game_sequencer
   import game_seq_pkg::*;
#(
   parameter int NUM_OBJ      = 4,
   parameter int PAINT_CYCLES = 1,
   parameter int CLEAR_CYCLES = 1,
   parameter int RUN_TIMEOUT  = 0,
   parameter int ROUND_W      = 8
) (
   input  logic               iClk,
   input  logic               iReset_n,
   input  logic               iStart,
   input  logic               iStop,
`ifdef GAME_SEQ_PAUSE_EN
   input  logic               iPause,
`endif
   output logic [NUM_OBJ-1:0] oEnablePosicionX,
   output logic [NUM_OBJ-1:0] oEnablePosicionY,
   output logic               oEnableLFSM,
   output logic               oPintar,
   output logic               oResetPintar,
   output logic [ROUND_W-1:0] oRound,
   output logic               oTimeout,
   output logic [STATE_W-1:0] oState
);

   localparam int CW = $clog2(maxOf4(NUM_OBJ, PAINT_CYCLES, CLEAR_CYCLES, RUN_TIMEOUT)) + 1;
   localparam bit TIMEOUT_EN = (RUN_TIMEOUT != 0);

   localparam logic [CW-1:0] INIT_LAST  = CW'(NUM_OBJ - 1);
   localparam logic [CW-1:0] PAINT_LAST = CW'(PAINT_CYCLES - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
   localparam logic [CW-1:0] RUN_LAST   = CW'(TIMEOUT_EN ? RUN_TIMEOUT - 1 : 0);

   state_t          state;
   state_t          stateNext;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   termVal;
   logic            cntTerm;
   logic            cntClear;
   logic            pauseLink;
   logic            timeoutExit;

   always_comb begin
      termVal = '0;
      case (state)
         ST_INIT:  termVal = INIT_LAST;
         ST_PAINT: termVal = PAINT_LAST;
         ST_RUN:   termVal = RUN_LAST;
         ST_CLEAR: termVal = CLEAR_LAST;
         default:  termVal = '0;
      endcase
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state <= ST_INIT;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext   = state;
      timeoutExit = 1'b0;
      case (state)
         ST_INIT: begin
            if (cntTerm) stateNext = ST_ARMED;
         end
         ST_ARMED: begin
            if (iStart) stateNext = ST_PAINT;
         end
         ST_PAINT: begin
            if (cntTerm) stateNext = ST_RUN;
         end
         ST_RUN: begin
            // Stop outranks timeout, so a simultaneous stop never flags oTimeout.
            if (iStop) begin
               stateNext = ST_CLEAR;
            end else if (TIMEOUT_EN && cntTerm) begin
               stateNext   = ST_CLEAR;
               timeoutExit = 1'b1;
            end
`ifdef GAME_SEQ_PAUSE_EN
            else if (iPause) begin
               stateNext = ST_PAUSE;
            end
`endif
         end
         ST_CLEAR: begin
            if (cntTerm) stateNext = ST_INIT;
         end
`ifdef GAME_SEQ_PAUSE_EN
         ST_PAUSE: begin
            if (iStop) begin
               stateNext = ST_CLEAR;
            end else if (!iPause) begin
               stateNext = ST_RUN;
            end
         end
`endif
         default: stateNext = ST_INIT;
      endcase
   end

   // RUN<->PAUSE hops keep the run count frozen instead of restarting it.
`ifdef GAME_SEQ_PAUSE_EN
   assign pauseLink = (stateNext == ST_PAUSE) || ((state == ST_PAUSE) && (stateNext == ST_RUN));
`else
   assign pauseLink = 1'b0;
`endif
   assign cntClear = (stateNext != state) && !pauseLink;

   game_seq_timer #(
      .W (CW)
   ) uTimer (
      .iClk     (iClk),
      .iReset_n (iReset_n),
      .iClear   (cntClear),
      .iHold    (pauseLink),
      .iLoad    (1'b0),
      .iLoadVal ('0),
      .iTermVal (termVal),
      .oCount   (cnt),
      .oTerm    (cntTerm)
   );

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         oRound   <= '0;
         oTimeout <= 1'b0;
      end else begin
         oTimeout <= timeoutExit;
         if ((stateNext == ST_CLEAR) && (state != ST_CLEAR)) begin
            oRound <= oRound + ROUND_W'(1);
         end
      end
   end

   always_comb begin
      oEnablePosicionX = '0;
      oEnablePosicionY = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if ((state == ST_INIT) && (cnt == CW'(i))) begin
            oEnablePosicionX[i] = 1'b1;
            oEnablePosicionY[i] = 1'b1;
         end
      end
   end

   assign oEnableLFSM  = (state == ST_INIT);
   assign oPintar      = (state == ST_PAINT);
   assign oResetPintar = (state == ST_CLEAR);
   assign oState       = state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed table-driven bench for game_sequencer (pause checks with GAME_SEQ_PAUSE_EN)
module tb_game_sequencer;

   localparam int NUM_OBJ      = 4;
   localparam int PAINT_CYCLES = 3;
   localparam int CLEAR_CYCLES = 2;
   localparam int RUN_TIMEOUT  = 10;
   localparam int ROUND_W      = 2;

   logic               iClk     = 1'b0;
   logic               iReset_n = 1'b0;
   logic               iStart   = 1'b0;
   logic               iStop    = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
   logic               iPause   = 1'b0;
`endif
   logic [NUM_OBJ-1:0] oEnablePosicionX;
   logic [NUM_OBJ-1:0] oEnablePosicionY;
   logic               oEnableLFSM;
   logic               oPintar;
   logic               oResetPintar;
   logic [ROUND_W-1:0] oRound;
   logic               oTimeout;
   logic [2:0]         oState;

   game_sequencer #(
      .NUM_OBJ      (NUM_OBJ),
      .PAINT_CYCLES (PAINT_CYCLES),
      .CLEAR_CYCLES (CLEAR_CYCLES),
      .RUN_TIMEOUT  (RUN_TIMEOUT),
      .ROUND_W      (ROUND_W)
   ) dut (
      .iClk             (iClk),
      .iReset_n         (iReset_n),
      .iStart           (iStart),
      .iStop            (iStop),
`ifdef GAME_SEQ_PAUSE_EN
      .iPause           (iPause),
`endif
      .oEnablePosicionX (oEnablePosicionX),
      .oEnablePosicionY (oEnablePosicionY),
      .oEnableLFSM      (oEnableLFSM),
      .oPintar          (oPintar),
      .oResetPintar     (oResetPintar),
      .oRound           (oRound),
      .oTimeout         (oTimeout),
      .oState           (oState)
   );

   always #5 iClk = ~iClk;

   // {state, X, Y, lfsm, pintar, resetPintar, timeout, round}
   logic [16:0] outVec;
   assign outVec = {oState, oEnablePosicionX, oEnablePosicionY, oEnableLFSM,
                    oPintar, oResetPintar, oTimeout, oRound};

   typedef struct {
      logic        start;
      logic        stop;
      logic [16:0] exp;
   } vec_t;

   vec_t vecs[18];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [16:0] mk(input logic [2:0] st, input logic [3:0] xy, input logic lfsm,
                                      input logic pint, input logic rp, input logic to,
                                      input logic [1:0] rnd);
      return {st, xy, xy, lfsm, pint, rp, to, rnd};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic waitState(input logic [2:0] s, input int maxC, input string name);
      int n;
      n = 0;
      while (oState !== s && n < maxC) begin
         @(negedge iClk);
         n++;
      end
      check(name, 32'(oState), 32'(s));
   endtask

   task automatic startRound();
      waitState(3'd1, 20, "wait_armed");
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
   endtask

   initial begin
      int pc;
      int rc;

      vecs[0]  = '{0, 0, mk(3'd0, 4'b0001, 1, 0, 0, 0, 2'd0)};
      vecs[1]  = '{0, 0, mk(3'd0, 4'b0010, 1, 0, 0, 0, 2'd0)};
      vecs[2]  = '{0, 0, mk(3'd0, 4'b0100, 1, 0, 0, 0, 2'd0)};
      vecs[3]  = '{0, 0, mk(3'd0, 4'b1000, 1, 0, 0, 0, 2'd0)};
      vecs[4]  = '{1, 0, mk(3'd1, 4'b0000, 0, 0, 0, 0, 2'd0)};
      vecs[5]  = '{0, 1, mk(3'd2, 4'b0000, 0, 1, 0, 0, 2'd0)};
      vecs[6]  = '{0, 1, mk(3'd2, 4'b0000, 0, 1, 0, 0, 2'd0)};
      vecs[7]  = '{0, 1, mk(3'd2, 4'b0000, 0, 1, 0, 0, 2'd0)};
      vecs[8]  = '{0, 0, mk(3'd3, 4'b0000, 0, 0, 0, 0, 2'd0)};
      vecs[9]  = '{0, 0, mk(3'd3, 4'b0000, 0, 0, 0, 0, 2'd0)};
      vecs[10] = '{0, 1, mk(3'd3, 4'b0000, 0, 0, 0, 0, 2'd0)};
      vecs[11] = '{0, 0, mk(3'd4, 4'b0000, 0, 0, 1, 0, 2'd1)};
      vecs[12] = '{0, 0, mk(3'd4, 4'b0000, 0, 0, 1, 0, 2'd1)};
      vecs[13] = '{0, 0, mk(3'd0, 4'b0001, 1, 0, 0, 0, 2'd1)};
      vecs[14] = '{0, 0, mk(3'd0, 4'b0010, 1, 0, 0, 0, 2'd1)};
      vecs[15] = '{0, 0, mk(3'd0, 4'b0100, 1, 0, 0, 0, 2'd1)};
      vecs[16] = '{0, 0, mk(3'd0, 4'b1000, 1, 0, 0, 0, 2'd1)};
      vecs[17] = '{0, 0, mk(3'd1, 4'b0000, 0, 0, 0, 0, 2'd1)};

      iReset_n = 1'b0;
      repeat (2) @(negedge iClk);
      check("reset_decode", 32'(outVec), 32'(mk(3'd0, 4'b0001, 1, 0, 0, 0, 2'd0)));
      iReset_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         if (i > 0) @(negedge iClk);
         iStart = vecs[i].start;
         iStop  = vecs[i].stop;
         check($sformatf("vec%0d", i), 32'(outVec), 32'(vecs[i].exp));
      end

      // Timeout round: paint burst length, then 10 RUN cycles before forced clear.
      @(negedge iClk);
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      pc = 0;
      while (oPintar && pc < 20) begin
         pc++;
         @(negedge iClk);
      end
      check("paint_len", 32'(pc), 32'(PAINT_CYCLES));
      check("run_entry", 32'(oState), 32'd3);
      rc = 0;
      while (oState == 3'd3 && rc < 50) begin
         rc++;
         @(negedge iClk);
      end
      check("run_len_timeout", 32'(rc), 32'(RUN_TIMEOUT));
      check("timeout_state", 32'(oState), 32'd4);
      check("timeout_pulse", 32'(oTimeout), 32'd1);
      check("timeout_round", 32'(oRound), 32'd2);
      @(negedge iClk);
      check("timeout_one_cycle", 32'(oTimeout), 32'd0);
      check("clear_second", 32'(oResetPintar), 32'd1);
      @(negedge iClk);
      check("init_after_clear", 32'(oState), 32'd0);

      // Rounds 3..5 by timeout: round counter wraps 3 -> 0 -> 1.
      for (int r = 3; r <= 5; r++) begin
         startRound();
         waitState(3'd4, 40, "wait_clear");
         check($sformatf("round%0d_count", r), 32'(oRound), 32'(r % 4));
         check($sformatf("round%0d_timeout", r), 32'(oTimeout), 32'd1);
      end

      // Asynchronous reset mid-PAINT.
      startRound();
      check("in_paint", 32'(oState), 32'd2);
      #2 iReset_n = 1'b0;
      #1 check("async_reset", 32'(outVec), 32'(mk(3'd0, 4'b0001, 1, 0, 0, 0, 2'd0)));
      @(negedge iClk);
      iReset_n = 1'b1;

`ifdef GAME_SEQ_PAUSE_EN
      // Pause at RUN cnt=4 for 5 cycles, then 6 RUN cycles remain before timeout.
      startRound();
      waitState(3'd3, 10, "pause_run_entry");
      repeat (4) @(negedge iClk);
      iPause = 1'b1;
      @(negedge iClk);
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("pause_cycle%0d", k), 32'(oState), 32'd5);
         if (k == 5) iPause = 1'b0;
         @(negedge iClk);
      end
      rc = 0;
      while (oState == 3'd3 && rc < 50) begin
         rc++;
         @(negedge iClk);
      end
      check("run_after_resume", 32'(rc), 32'd6);
      check("pause_timeout", 32'(oTimeout), 32'd1);
      check("pause_round", 32'(oRound), 32'd1);

      // Stop while paused goes straight to CLEAR without a timeout flag.
      startRound();
      waitState(3'd3, 10, "stop_run_entry");
      @(negedge iClk);
      iPause = 1'b1;
      @(negedge iClk);
      check("paused", 32'(oState), 32'd5);
      iStop = 1'b1;
      @(negedge iClk);
      iStop  = 1'b0;
      iPause = 1'b0;
      check("stop_in_pause", 32'(oState), 32'd4);
      check("stop_in_pause_to", 32'(oTimeout), 32'd0);
      check("stop_in_pause_round", 32'(oRound), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
